// File: rtl/tx_pause_sched.sv
// Pause-frame scheduler for the 10G TX encapsulator: turns RX fill level versus watermarks into
// XOFF / XOFF-refresh / XON requests on the xreq/xon/xdone handshake, with handshake timeout.
module tx_pause_sched #(
  parameter int LVL_W       = 16,
  parameter int QUANTA_CLKS = 8,
  parameter int REFRESH_MRG = 4,
  parameter int HS_TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             pause_en,
  input  logic [LVL_W-1:0] rx_level,
  input  logic [LVL_W-1:0] hi_wm,
  input  logic [LVL_W-1:0] lo_wm,
  input  logic [31:0]      mac_pause_value,
  input  logic             xdone,
  output logic             xreq,
  output logic             xon,
  output logic             paused,
  output logic [15:0]      pframe_cnt,
  output logic             hs_err
);

  localparam int PS_W = (QUANTA_CLKS > 1) ? $clog2(QUANTA_CLKS) : 1;
  localparam int TO_W = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(QUANTA_CLKS - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(HS_TIMEOUT - 1);
  localparam logic [15:0]     MRG    = 16'(REFRESH_MRG);

  localparam logic [4:0] S_IDLE     = 5'b00001;
  localparam logic [4:0] S_XOFF_REQ = 5'b00010;
  localparam logic [4:0] S_PAUSED   = 5'b00100;
  localparam logic [4:0] S_REFR_REQ = 5'b01000;
  localparam logic [4:0] S_XON_REQ  = 5'b10000;

  logic [4:0]      state;
  logic [PS_W-1:0] presc;
  logic [15:0]     refresh;
  logic [TO_W-1:0] to_cnt;

  logic [15:0] pval;
  logic [15:0] refresh_load;
  logic        fc_en;
  logic        xoff_cond;
  logic        xon_cond;
  logic        done;
  logic        to_hit;
  logic        unused_bits;

  assign pval         = mac_pause_value[31:16];
  assign unused_bits  = &{1'b0, mac_pause_value[15:0]};
  // A zero pause value would make every XOFF a no-op, so it disables flow control outright.
  assign fc_en        = pause_en && (pval != 16'd0);
  assign xoff_cond    = fc_en && (rx_level >= hi_wm);
  assign xon_cond     = !fc_en || (rx_level < lo_wm);
  assign refresh_load = (pval > MRG) ? (pval - MRG) : 16'd1;
  assign done         = xreq && xdone;
  assign to_hit       = xreq && !xdone && (to_cnt == TO_MAX);

  // NOTE: all state below uses non-blocking assignments so every branch reads pre-edge values;
  // the async reset clears everything, including counters, so no output depends on power-up junk.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= S_IDLE;
      xreq       <= 1'b0;
      xon        <= 1'b0;
      paused     <= 1'b0;
      pframe_cnt <= 16'd0;
      hs_err     <= 1'b0;
      presc      <= '0;
      refresh    <= 16'd0;
      to_cnt     <= '0;
    end else begin
      if (!xreq || done || to_hit) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;

      if (done && (pframe_cnt != 16'hFFFF)) pframe_cnt <= pframe_cnt + 16'd1;
      if (to_hit) hs_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (xoff_cond) begin
            state <= S_XOFF_REQ;
            xreq  <= 1'b1;
            xon   <= 1'b1;
          end
        end
        S_XOFF_REQ: begin
          if (done) begin
            state   <= S_PAUSED;
            xreq    <= 1'b0;
            paused  <= 1'b1;
            refresh <= refresh_load;
            presc   <= PS_MAX;
          end else if (to_hit) begin
            state <= S_IDLE;
            xreq  <= 1'b0;
          end
        end
        S_PAUSED: begin
          // Drain/disable outranks refresh expiry in the same cycle.
          if (xon_cond) begin
            state <= S_XON_REQ;
            xreq  <= 1'b1;
            xon   <= 1'b0;
          end else if (refresh == 16'd0) begin
            state <= S_REFR_REQ;
            xreq  <= 1'b1;
            xon   <= 1'b1;
          end else if (presc == '0) begin
            presc   <= PS_MAX;
            refresh <= refresh - 16'd1;
          end else begin
            presc <= presc - 1'b1;
          end
        end
        S_REFR_REQ: begin
          if (done) begin
            state   <= S_PAUSED;
            xreq    <= 1'b0;
            refresh <= refresh_load;
            presc   <= PS_MAX;
          end else if (to_hit) begin
            // Back to PAUSED with an expired timer so the refresh is retried next cycle.
            state   <= S_PAUSED;
            xreq    <= 1'b0;
            refresh <= 16'd0;
          end
        end
        S_XON_REQ: begin
          // xreq low here means a timed-out XON waiting one idle cycle before re-requesting.
          if (done) begin
            state  <= S_IDLE;
            xreq   <= 1'b0;
            paused <= 1'b0;
          end else if (to_hit) begin
            xreq <= 1'b0;
          end else if (!xreq) begin
            xreq <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          xreq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pause_sched.sv
// Scoreboard bench for tx_pause_sched: each stimulus that must provoke a pause request pushes the
// expected xon value; a monitor pops and compares on every xreq rising edge.
module tb_tx_pause_sched;

  localparam int LVL_W = 16;
  localparam int QCLK  = 8;
  localparam int MRG   = 4;
  localparam int HS_TO = 16;

  logic             clk = 1'b0;
  logic             rst_;
  logic             pause_en;
  logic [LVL_W-1:0] rx_level;
  logic [LVL_W-1:0] hi_wm;
  logic [LVL_W-1:0] lo_wm;
  logic [31:0]      mac_pause_value;
  logic             xdone;
  logic             xreq;
  logic             xon;
  logic             paused;
  logic [15:0]      pframe_cnt;
  logic             hs_err;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_xon_q[$];
  logic xreq_prev = 1'b0;

  tx_pause_sched #(
    .LVL_W(LVL_W), .QUANTA_CLKS(QCLK), .REFRESH_MRG(MRG), .HS_TIMEOUT(HS_TO)
  ) dut (
    .clk(clk), .rst_(rst_), .pause_en(pause_en), .rx_level(rx_level), .hi_wm(hi_wm),
    .lo_wm(lo_wm), .mac_pause_value(mac_pause_value), .xdone(xdone), .xreq(xreq), .xon(xon),
    .paused(paused), .pframe_cnt(pframe_cnt), .hs_err(hs_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every new request must match the next expected xon value.
  always @(negedge clk) begin
    if (rst_ && xreq && !xreq_prev) begin
      if (exp_xon_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
      else check("req_xon", 32'(xon), 32'(exp_xon_q.pop_front()));
    end
    xreq_prev <= xreq;
  end

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk);
    while (!xreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(xreq), 32'd1);
  endtask

  // Ends on the negedge right after the edge that sampled xdone.
  task automatic pulse_xdone();
    @(posedge clk); #1 xdone = 1'b1;
    @(posedge clk); #1 xdone = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_level(input logic [LVL_W-1:0] lvl);
    @(posedge clk); #1 rx_level = lvl;
  endtask

  initial begin
    int hi_seen;
    int hi_len;

    rst_            = 1'b0;
    pause_en        = 1'b1;
    rx_level        = 16'd47;
    hi_wm           = 16'd48;
    lo_wm           = 16'd16;
    mac_pause_value = {16'd100, 16'hABCD};
    xdone           = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;

    // 1: reset state, threshold boundary 47 -> 48, first XOFF.
    repeat (3) @(negedge clk);
    check("rst_outs", {xreq, xon, paused, hs_err, pframe_cnt}, 32'd0);
    set_level(16'd48);
    exp_xon_q.push_back(1'b1);
    @(negedge clk);
    check("t1_not_early", 32'(xreq), 32'd0);
    @(negedge clk);
    check("t1_xreq", {xreq, xon}, 32'b11);
    pulse_xdone();
    check("t1_done", {xreq, paused, pframe_cnt}, {14'd0, 1'b0, 1'b1, 16'd1});

    // 2: level held above lo_wm; refresh = 100-4 = 96 quanta of 8 clocks. The timer hits zero
    // 768 edges after the xdone edge; xreq, being registered, rises on the next edge.
    rx_level = 16'd60;
    exp_xon_q.push_back(1'b1);
    hi_seen = 0;
    for (int k = 1; k <= 96 * QCLK; k++) begin
      @(negedge clk);
      if (xreq) hi_seen++;
    end
    check("t2_quiet", hi_seen, 32'd0);
    check("t2_paused", 32'(paused), 32'd1);
    @(negedge clk);
    check("t2_refresh", {xreq, xon}, 32'b11);
    pulse_xdone();
    check("t2_done", {xreq, paused, pframe_cnt}, {14'd0, 1'b0, 1'b1, 16'd2});

    // 3: drain below lo_wm -> XON; then re-cross hi_wm -> XOFF again.
    set_level(16'd15);
    exp_xon_q.push_back(1'b0);
    wait_req("t3_xon_req");
    pulse_xdone();
    check("t3_xon_done", {xreq, paused, pframe_cnt}, {14'd0, 1'b0, 1'b0, 16'd3});
    set_level(16'd48);
    exp_xon_q.push_back(1'b1);
    wait_req("t3_rexoff");
    pulse_xdone();
    check("t3_rexoff_done", {paused, pframe_cnt}, {15'd0, 1'b1, 16'd4});
    set_level(16'd10);
    exp_xon_q.push_back(1'b0);
    wait_req("t3_xon2_req");
    pulse_xdone();
    check("t3_idle", {xreq, paused, pframe_cnt}, {14'd0, 1'b0, 1'b0, 16'd5});

    // 4: level collapses during XOFF_REQ: request is held, XOFF completes, XON follows next cycle.
    set_level(16'd50);
    exp_xon_q.push_back(1'b1);
    wait_req("t4_xoff_req");
    set_level(16'd0);
    repeat (3) @(negedge clk);
    check("t4_held", {xreq, xon}, 32'b11);
    exp_xon_q.push_back(1'b0);
    pulse_xdone();
    check("t4_paused", {xreq, paused, pframe_cnt}, {14'd0, 1'b0, 1'b1, 16'd6});
    @(negedge clk);
    check("t4_xon_next", {xreq, xon}, 32'b10);
    pulse_xdone();
    check("t4_idle", {paused, pframe_cnt}, {15'd0, 1'b0, 16'd7});

    // 5: XOFF never acknowledged -> xreq high exactly HS_TO clocks, hs_err sticky, back to IDLE.
    set_level(16'd50);
    exp_xon_q.push_back(1'b1);
    wait_req("t5_req");
    hi_len = 1;
    exp_xon_q.push_back(1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!xreq) break;
      hi_len++;
    end
    check("t5_hi_len", hi_len, HS_TO);
    check("t5_err", {hs_err, paused, pframe_cnt}, {14'd0, 1'b1, 1'b0, 16'd7});
    wait_req("t5_retry");
    pulse_xdone();
    check("t5_sticky", {hs_err, paused, pframe_cnt}, {14'd0, 1'b1, 1'b1, 16'd8});
    // XON timeout: one low cycle, then the same XON is requested again.
    set_level(16'd0);
    exp_xon_q.push_back(1'b0);
    wait_req("t5_xon_req");
    hi_len = 1;
    exp_xon_q.push_back(1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!xreq) break;
      hi_len++;
    end
    check("t5_xon_hi_len", hi_len, HS_TO);
    check("t5_xon_gap", {xreq, paused}, 32'b01);
    @(negedge clk);
    check("t5_xon_again", {xreq, xon}, 32'b10);
    pulse_xdone();
    check("t5_xon_done", {paused, pframe_cnt}, {15'd0, 1'b0, 16'd9});

    // 6: pval=0 blocks XOFF at any level; then async reset in the middle of a request.
    mac_pause_value = 32'h0000_FFFF;
    set_level(16'hFFFF);
    hi_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (xreq) hi_seen++;
    end
    check("t6_pval0", hi_seen, 32'd0);
    mac_pause_value = {16'd100, 16'd0};
    exp_xon_q.push_back(1'b1);
    wait_req("t6_req");
    #1 rst_ = 1'b0;
    #1 check("t6_async_rst", {xreq, xon, paused, hs_err, pframe_cnt}, 32'd0);
    pause_en = 1'b0;
    xdone = 1'b1;
    @(posedge clk); #1 xdone = 1'b0;
    rst_ = 1'b1;
    pulse_xdone();
    repeat (2) @(negedge clk);
    check("t6_xdone_ignored", {xreq, paused, hs_err, pframe_cnt}, 32'd0);

    check("sb_drained", exp_xon_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
